cw8_tracker: RTL and testbench
==============================

# cw8_tracker

Receive-side monitor for the clockwise-8 seven-segment animation. It samples a 7-bit segment bus, filters glitches, and decodes each stable frame back to its 3-bit step index, using sequence context to resolve the segment-g ambiguity. It reports lock, sequence errors and completed laps. It sits on the display side of a segment link, or in a self-test loop watching the animation generator's output.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed to accept a frame (>= 1)
- LAP_W, 8, width of lap counter

Ports:
- i_clk  input  1  clock (one clock domain)
- i_rst_n  input  1  reset, asynchronous, active-low
- i_enable  input  1  tracking enable
- i_segment  input  7  segment bus, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g
- o_count  output  3  decoded step index
- o_locked  output  1  tracker is following the sequence
- o_error  output  1  one-cycle pulse on an illegal or out-of-order frame
- o_lap_done  output  1  one-cycle pulse when a 7->0 step is accepted
- o_lap_count  output  LAP_W  completed laps, saturating

## Operation
- Reset values:
  - o_count=0, o_locked=0, o_error=0, o_lap_done=0, o_lap_count=0.
  - Internal: state SEARCH, sample register 0, run counter 0, last-accepted pattern 0.
- Sampling and filtering:
  - i_segment is registered every cycle.
  - The run counter restarts at 1 when the registered sample differs from the previous sample, and increments (saturating) while it is equal.
  - A frame is accepted on the cycle the run counter reaches STABLE_CYCLES.
  - While i_enable=0, the run counter is held at 0, no frame is accepted, and state and outputs are held (o_error and o_lap_done are 0).
- Frame classes:
  - Blank (7'b0000000): ignored. No state change, no error. It does not update the last-accepted pattern.
  - Repeat (equal to the last-accepted non-blank pattern): ignored.
  - Legal one-hot: a->0, b->1, e->3, d->4, c->5, f->7; g->{2,6}.
  - Illegal: any other pattern.
- FSM state SEARCH:
  - Legal non-g frame: o_count is loaded with its index, o_locked=1, go to LOCKED.
  - g frame: ignored, because the index is ambiguous.
  - Illegal frame: o_error pulse, stay in SEARCH.
- FSM state LOCKED (expected index = o_count+1 mod 8):
  - Frame matches the expected index's pattern: o_count <= expected. A g frame is resolved to 2 or 6 by the expected index.
  - Frame with o_count=7 advancing to 0: o_lap_done pulse, and o_lap_count increments unless all-ones. The pulse is still issued at saturation.
  - Any other legal or illegal frame: o_error pulse, o_locked=0, go to SEARCH, and o_count holds its last value. The offending frame does not itself relock; the next accepted new frame is evaluated in SEARCH.
- The last-accepted pattern updates on every accepted non-blank frame, including error frames.
- Error and lap pulses are mutually exclusive by construction.

## Timing
- Let edge k be the first clock edge at which a new i_segment value is sampled.
- With the value held, the frame is accepted and o_count, o_locked, o_error and o_lap_done update on edge k+STABLE_CYCLES.
  - Default latency: 4 cycles.
  - With STABLE_CYCLES=1: 1 cycle.
- A value held for fewer than STABLE_CYCLES sampling edges is never accepted.
- o_error and o_lap_done are high for exactly one cycle per event.
- Asynchronous reset forces all outputs and state to reset values immediately, independent of i_clk. Operation resumes at the first edge after deassertion. A partially filtered frame is discarded.

## Test plan
- Clean lap: default parameters, enable=1, frames a,b,g,e,d,c,g,f,a each held 6 cycles -> lock on a with o_count=0 four cycles after a's first sample edge. o_count then steps 1,2,3,4,5,6,7,0. One o_lap_done pulse, o_lap_count=1, o_error never asserted.
- Ambiguity: from reset, g held 6 then e held 6 -> g ignored (o_locked=0), lock on e with o_count=3. Then d -> 4, c -> 5, g -> 6.
- Glitch and blank:
  - Locked at 0 (a), apply b for 2 cycles then a again -> no change, no error.
  - a, blank (6 cycles), a -> no error, o_count stays 0.
- Out-of-order: locked at o_count=1, apply e -> single o_error pulse, o_locked=0, o_count=1. Then d -> relock with o_count=4.
- Illegal: apply 7'b0000011 held 6 cycles in SEARCH -> one o_error pulse, state stays SEARCH. Apply the same in LOCKED -> o_error pulse, o_locked=0.
- Saturation and reset: LAP_W=2, run 4 clean laps -> o_lap_count 1,2,3,3 with 4 o_lap_done pulses. Then drop i_rst_n between clock edges -> all outputs 0 immediately.
- Enable: i_enable=0 while a new frame is applied -> no acceptance. Raise i_enable -> acceptance STABLE_CYCLES cycles later.

Source files
------------

// File: rtl/cw8_tracker.sv
// cw8_tracker: receive-side monitor for the clockwise-8 segment animation.
// Filters the segment bus, decodes step indices, tracks lock and laps.
module cw8_tracker #(
    parameter int STABLE_CYCLES = 4,
    parameter int LAP_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [6:0]       i_segment,
    output logic [2:0]       o_count,
    output logic             o_locked,
    output logic             o_error,
    output logic             o_lap_done,
    output logic [LAP_W-1:0] o_lap_count
);

    // Run counter saturates one past the threshold so a held frame fires once.
    localparam int RUN_MAX = STABLE_CYCLES + 1;
    localparam int RW      = $clog2(RUN_MAX + 1);
    localparam logic [RW-1:0] RUN_TOP = RW'(RUN_MAX);
    localparam logic [RW-1:0] RUN_ACC = RW'(STABLE_CYCLES);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t           state, state_d;
    logic [6:0]       seg_q;
    logic [6:0]       last, last_d;
    logic [RW-1:0]    run, run_d;
    logic [2:0]       count, count_d;
    logic             err_d, lap_d;
    logic [LAP_W-1:0] lap_cnt, lap_cnt_d;

    logic             accept;
    logic [2:0]       exp_idx;
    logic [6:0]       exp_pat;
    logic [2:0]       dec_idx;
    logic             dec_ok;
    logic             is_g;

    assign accept  = i_enable && (run == RUN_ACC);
    assign exp_idx = count + 3'd1;
    assign is_g    = (seg_q == 7'h40);

    always_comb begin
        run_d = run;
        if (!i_enable)
            run_d = '0;
        else if (i_segment != seg_q)
            run_d = RW'(1);
        else if (run != RUN_TOP)
            run_d = run + RW'(1);
    end

    always_comb begin
        exp_pat = 7'h40;
        case (exp_idx)
            3'd0: exp_pat = 7'h01;
            3'd1: exp_pat = 7'h02;
            3'd3: exp_pat = 7'h10;
            3'd4: exp_pat = 7'h08;
            3'd5: exp_pat = 7'h04;
            3'd7: exp_pat = 7'h20;
            default: exp_pat = 7'h40;
        endcase
    end

    // Unambiguous one-hot frames only; g needs sequence context.
    always_comb begin
        dec_idx = 3'd0;
        dec_ok  = 1'b1;
        case (seg_q)
            7'h01: dec_idx = 3'd0;
            7'h02: dec_idx = 3'd1;
            7'h10: dec_idx = 3'd3;
            7'h08: dec_idx = 3'd4;
            7'h04: dec_idx = 3'd5;
            7'h20: dec_idx = 3'd7;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state;
        count_d   = count;
        err_d     = 1'b0;
        lap_d     = 1'b0;
        lap_cnt_d = lap_cnt;
        last_d    = last;
        if (accept && seg_q != 7'h00 && seg_q != last) begin
            last_d = seg_q;
            case (state)
                SEARCH: begin
                    if (dec_ok) begin
                        count_d = dec_idx;
                        state_d = LOCKED;
                    end else if (!is_g) begin
                        err_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (seg_q == exp_pat) begin
                        count_d = exp_idx;
                        if (count == 3'd7) begin
                            lap_d = 1'b1;
                            if (lap_cnt != '1)
                                lap_cnt_d = lap_cnt + LAP_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_q      <= '0;
            run        <= '0;
            state      <= SEARCH;
            count      <= '0;
            last       <= '0;
            o_error    <= 1'b0;
            o_lap_done <= 1'b0;
            lap_cnt    <= '0;
        end else begin
            seg_q      <= i_segment;
            run        <= run_d;
            state      <= state_d;
            count      <= count_d;
            last       <= last_d;
            o_error    <= err_d;
            o_lap_done <= lap_d;
            lap_cnt    <= lap_cnt_d;
        end
    end

    assign o_count     = count;
    assign o_locked    = (state == LOCKED);
    assign o_lap_count = lap_cnt;

endmodule

// File: tb/tb_cw8_tracker.sv
// Directed bench for cw8_tracker: default instance plus a LAP_W=2
// instance on the same stimulus for lap-counter saturation.
module tb_cw8_tracker;

    localparam logic [6:0] SA = 7'h01;
    localparam logic [6:0] SB = 7'h02;
    localparam logic [6:0] SC = 7'h04;
    localparam logic [6:0] SD = 7'h08;
    localparam logic [6:0] SE = 7'h10;
    localparam logic [6:0] SF = 7'h20;
    localparam logic [6:0] SG = 7'h40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] seg;

    logic [2:0] cnt, cnt2;
    logic       locked, locked2;
    logic       err, err2;
    logic       lap, lap2;
    logic [7:0] lapc;
    logic [1:0] lapc2;

    int total = 0;
    int bad   = 0;
    int err_n = 0;
    int lap_n = 0;
    int lap2_n = 0;
    int e0, l0;

    logic [6:0] lap_pat [8];
    logic [2:0] lap_idx [8];

    cw8_tracker u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_segment  (seg),
        .o_count    (cnt),
        .o_locked   (locked),
        .o_error    (err),
        .o_lap_done (lap),
        .o_lap_count(lapc)
    );

    cw8_tracker #(.STABLE_CYCLES(4), .LAP_W(2)) u_sat (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_segment  (seg),
        .o_count    (cnt2),
        .o_locked   (locked2),
        .o_error    (err2),
        .o_lap_done (lap2),
        .o_lap_count(lapc2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (err) err_n++;
        if (lap) lap_n++;
        if (lap2) lap2_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_lap(input string tag);
        for (int i = 0; i < 8; i++) begin
            hold(lap_pat[i], 6);
            chk({tag, "_count"}, 32'(cnt), 32'(lap_idx[i]));
        end
    endtask

    initial begin
        lap_pat = '{SB, SG, SE, SD, SC, SG, SF, SA};
        lap_idx = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        rst_n = 1'b0;
        enable = 1'b1;
        seg = 7'h00;
        #2;
        chk("rst_count", 32'(cnt), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_error", 32'(err), 0);
        chk("rst_lap", 32'(lap), 0);
        chk("rst_lapc", 32'(lapc), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // clean lap with exact lock latency
        e0 = err_n;
        seg = SA;
        repeat (4) @(negedge clk);
        chk("lat_early_locked", 32'(locked), 0);
        @(negedge clk);
        chk("lat_locked", 32'(locked), 1);
        chk("lat_count", 32'(cnt), 0);
        @(negedge clk);
        l0 = lap_n;
        run_lap("lap1");
        chk("lap1_pulses", 32'(lap_n - l0), 1);
        chk("lap1_lapc", 32'(lapc), 1);
        chk("lap1_sat", 32'(lapc2), 1);
        chk("lap1_errors", 32'(err_n - e0), 0);

        // glitch shorter than the filter, then blank
        hold(SB, 2);
        hold(SA, 6);
        chk("glitch_count", 32'(cnt), 0);
        chk("glitch_locked", 32'(locked), 1);
        hold(7'h00, 6);
        hold(SA, 6);
        chk("blank_count", 32'(cnt), 0);
        chk("blank_errors", 32'(err_n - e0), 0);

        // out of order
        hold(SB, 6);
        chk("ooo_pre_count", 32'(cnt), 1);
        e0 = err_n;
        hold(SE, 6);
        chk("ooo_err", 32'(err_n - e0), 1);
        chk("ooo_locked", 32'(locked), 0);
        chk("ooo_count", 32'(cnt), 1);
        hold(SD, 6);
        chk("relock_locked", 32'(locked), 1);
        chk("relock_count", 32'(cnt), 4);

        // illegal frames
        e0 = err_n;
        hold(7'b0000011, 6);
        chk("ill_lk_err", 32'(err_n - e0), 1);
        chk("ill_lk_locked", 32'(locked), 0);
        chk("ill_lk_count", 32'(cnt), 4);
        hold(7'b1100000, 6);
        chk("ill_s1_err", 32'(err_n - e0), 2);
        hold(7'b0000011, 6);
        chk("ill_s2_err", 32'(err_n - e0), 3);
        chk("ill_s_locked", 32'(locked), 0);

        // g is ambiguous in search
        e0 = err_n;
        hold(SG, 6);
        chk("amb_g_locked", 32'(locked), 0);
        chk("amb_g_count", 32'(cnt), 4);
        hold(SE, 6);
        chk("amb_e_locked", 32'(locked), 1);
        chk("amb_e_count", 32'(cnt), 3);
        hold(SD, 6);
        chk("amb_d_count", 32'(cnt), 4);
        hold(SC, 6);
        chk("amb_c_count", 32'(cnt), 5);
        hold(SG, 6);
        chk("amb_g6_count", 32'(cnt), 6);
        hold(SF, 6);
        hold(SA, 6);
        chk("amb_wrap_count", 32'(cnt), 0);
        chk("amb_lapc", 32'(lapc), 2);
        chk("amb_sat", 32'(lapc2), 2);
        chk("amb_errors", 32'(err_n - e0), 0);

        // saturation of the narrow lap counter
        run_lap("lap3");
        chk("lap3_sat", 32'(lapc2), 3);
        run_lap("lap4");
        chk("lap4_sat", 32'(lapc2), 3);
        chk("lap4_lapc", 32'(lapc), 4);
        chk("sat_pulses", 32'(lap2_n), 4);

        // enable gating
        enable = 1'b0;
        hold(SB, 8);
        chk("dis_count", 32'(cnt), 0);
        chk("dis_locked", 32'(locked), 1);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("en_early_count", 32'(cnt), 0);
        @(negedge clk);
        chk("en_count", 32'(cnt), 1);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(cnt), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_lapc", 32'(lapc), 0);
        chk("arst_sat", 32'(lapc2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // illegal frame straight out of reset
        e0 = err_n;
        hold(7'b0000011, 6);
        chk("post_ill_err", 32'(err_n - e0), 1);
        chk("post_ill_locked", 32'(locked), 0);
        hold(SC, 6);
        chk("post_lock_count", 32'(cnt), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
